// File: rtl/op_receiver.sv
// op_receiver
// Serial front end of the NeXT monitor-bus path. Recovers 26-bit frames
// (start 0, 24 data bits MSB-first, stop 1) from the asynchronous host line
// and emits each 24-bit operation word with a one-cycle valid strobe.
//
// Ports:
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   serial_in    raw serial line, idle high, asynchronous to clk
//   op           last received operation word (held between strobes)
//   op_valid     one-cycle strobe, op holds a new word
//   frame_error  one-cycle strobe, stop bit sampled low
//   busy         high in START, DATA, STOP and BREAK
//
// Build option:
//   OPRX_MAJORITY_EN  each bit sample is the 2-of-3 vote of rx over the
//                     cnt = 2, 1, 0 cycles instead of a single cnt = 0 sample.
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle, watching for a falling edge of rx
// START | counting to mid start bit, rejects glitches
// DATA  | shifting in 24 data bits, one per bit cell
// STOP  | counting to mid stop bit, strobes op_valid or frame_error
// BREAK | stop bit was low, waiting for the line to return high

module op_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        serial_in,
    output logic [23:0] op,
    output logic        op_valid,
    output logic        frame_error,
    output logic        busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          sync_q;
    logic          rx_q;
    logic          rx_prev_q;
    logic [2:0]    state_q,       state_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic [4:0]    bitn_q,        bitn_d;
    logic [23:0]   sr_q,          sr_d;
    logic [23:0]   op_q,          op_d;
    logic          op_valid_q,    op_valid_d;
    logic          frame_error_q, frame_error_d;
    logic          sample;

`ifdef OPRX_MAJORITY_EN
    // rx from the previous two cycles; cnt steps down by one per cycle, so at
    // cnt = 0 these hold the cnt = 1 and cnt = 2 samples.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) hist_q <= 2'b11;
        else       hist_q <= {hist_q[0], rx_q};
    end

    assign sample = (rx_q & hist_q[0]) | (rx_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample = rx_q;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bitn_d        = bitn_q;
        sr_d          = sr_q;
        op_d          = op_q;
        op_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // edge detection deliberately uses the raw synchronized rx
                if (rx_prev_q && !rx_q) begin
                    cnt_d   = HALF_M1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!sample) begin
                        state_d = S_DATA;
                        cnt_d   = FULL_M1;
                        bitn_d  = 5'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    sr_d   = {sr_q[22:0], sample};
                    cnt_d  = FULL_M1;
                    bitn_d = bitn_q + 5'd1;
                    if (bitn_q == 5'd23) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (sample) begin
                        op_d       = sr_q;
                        op_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_BREAK: begin
                // a held-low line must not be read as a stream of frames
                if (rx_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q        <= 1'b1;
            rx_q          <= 1'b1;
            rx_prev_q     <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bitn_q        <= 5'd0;
            sr_q          <= 24'h000000;
            op_q          <= 24'h000000;
            op_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            sync_q        <= serial_in;
            rx_q          <= sync_q;
            rx_prev_q     <= rx_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bitn_q        <= bitn_d;
            sr_q          <= sr_d;
            op_q          <= op_d;
            op_valid_q    <= op_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign op          = op_q;
    assign op_valid    = op_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_op_receiver.sv
module tb_op_receiver;

    localparam int C = 8;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        serial_in = 1'b1;
    logic [23:0] op;
    logic        op_valid;
    logic        frame_error;
    logic        busy;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    int fe_cnt = 0;
    logic [23:0] exp_q[$];
    logic [23:0] op_prev = 24'h0;
    logic        nrst_prev = 1'b0;

    op_receiver #(.CLKS_PER_BIT(C)) dut (
        .clk(clk),
        .nrst(nrst),
        .serial_in(serial_in),
        .op(op),
        .op_valid(op_valid),
        .frame_error(frame_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // scoreboard / strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (nrst && nrst_prev) begin
            if (op_valid && frame_error) begin
                total++; bad++;
                $display("FAIL strobe_overlap op_valid=%b frame_error=%b want not both", op_valid, frame_error);
            end
            if (frame_error) fe_cnt++;
            if (op_valid) begin
                valid_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_op_valid op=%h want no strobe", op);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    if (op !== e) begin
                        bad++;
                        $display("FAIL op_word got=%h want=%h", op, e);
                    end
                end
            end else begin
                total++;
                if (op !== op_prev) begin
                    bad++;
                    $display("FAIL op_hold got=%h want=%h", op, op_prev);
                end
            end
        end
        op_prev   = op;
        nrst_prev = nrst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        serial_in = v;
        tick(n);
    endtask

    task automatic send_frame(input logic [23:0] w, input logic stop, input int stop_cycles,
                              input bit noise);
        drive(1'b0, C);
        for (int i = 23; i >= 0; i--) begin
            if (noise) begin
                drive(w[i], C / 2);
                drive(~w[i], 1);
                drive(w[i], C / 2 - 1);
            end else begin
                drive(w[i], C);
            end
        end
        drive(stop, stop_cycles);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick(1);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick(3);
        chk("reset_op", 32'(op), 32'h0);
        chk("reset_op_valid", 32'(op_valid), 32'h0);
        chk("reset_frame_error", 32'(frame_error), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        nrst = 1'b1;
        tick(2 * C);
    endtask

    task automatic test_valid_frame();
        int v0 = valid_cnt;
        int f0 = fe_cnt;
        exp_q.push_back(24'hC71234);
        send_frame(24'hC71234, 1'b1, C, 1'b0);
        wait_empty("valid");
        tick(2);
        chk("valid_count", 32'(valid_cnt - v0), 32'd1);
        chk("valid_no_fe", 32'(fe_cnt - f0), 32'd0);
        chk("valid_busy_low", 32'(busy), 32'h0);
        chk("valid_op", 32'(op), 32'hC71234);
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        exp_q.push_back(24'hC5EF00);
        send_frame(24'hC5EF00, 1'b1, C / 2 + 1, 1'b0);
        exp_q.push_back(24'hFFFFFF);
        send_frame(24'hFFFFFF, 1'b1, C, 1'b0);
        tick(C);
        wait_empty("b2b");
        chk("b2b_count", 32'(valid_cnt - v0), 32'd2);
        chk("b2b_op", 32'(op), 32'hFFFFFF);
    endtask

    task automatic test_frame_error();
        int v0 = valid_cnt;
        int f0 = fe_cnt;
        logic [23:0] op0 = op;
        send_frame(24'h0B0000, 1'b0, 3 * C, 1'b0);
        chk("fe_count", 32'(fe_cnt - f0), 32'd1);
        chk("fe_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("fe_op_kept", 32'(op), 32'(op0));
        chk("fe_busy_held", 32'(busy), 32'h1);
        drive(1'b1, 2);
        chk("fe_busy_until_rise", 32'(busy), 32'h1);
        tick(2);
        chk("fe_busy_released", 32'(busy), 32'h0);
        tick(2 * C);
        chk("fe_no_restart", 32'(busy), 32'h0);
        chk("fe_no_extra", 32'(valid_cnt - v0 + fe_cnt - f0), 32'd1);
    endtask

    task automatic test_glitch();
        int v0 = valid_cnt;
        int f0 = fe_cnt;
        drive(1'b0, 2);
        drive(1'b1, 2);
        chk("glitch_start_seen", 32'(busy), 32'h1);
        tick(C);
        chk("glitch_idle", 32'(busy), 32'h0);
        chk("glitch_no_strobe", 32'(valid_cnt - v0 + fe_cnt - f0), 32'd0);
    endtask

    task automatic test_reset_mid_frame();
        logic [23:0] w = 24'hC40300;
        int v0;
        int f0;
        drive(1'b0, C);
        for (int i = 23; i >= 14; i--) drive(w[i], C);
        nrst = 1'b0;
        tick(1);
        chk("rst_mid_op", 32'(op), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_op_valid", 32'(op_valid), 32'h0);
        chk("rst_mid_frame_error", 32'(frame_error), 32'h0);
        serial_in = 1'b1;
        tick(2);
        nrst = 1'b1;
        v0 = valid_cnt;
        f0 = fe_cnt;
        tick(2 * C);
        chk("rst_mid_no_strobe", 32'(valid_cnt - v0 + fe_cnt - f0), 32'd0);
        exp_q.push_back(w);
        send_frame(w, 1'b1, C, 1'b0);
        tick(C);
        wait_empty("rst_mid");
        chk("rst_mid_next_op", 32'(op), 32'hC40300);
    endtask

    task automatic test_noise();
        logic [23:0] e;
`ifdef OPRX_MAJORITY_EN
        e = 24'h030000;
`else
        e = 24'hFCFFFF;
`endif
        exp_q.push_back(e);
        send_frame(24'h030000, 1'b1, C, 1'b1);
        tick(C);
        wait_empty("noise");
        chk("noise_op", 32'(op), 32'(e));
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_noise();
        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/op_receiver.md
# op_receiver

Serial front end of the NeXT monitor-bus path: recovers 26-bit frames from the asynchronous serial line sent by the NeXT host, checks framing and emits each 24-bit operation word with a one-cycle valid strobe. Its outputs `op` / `op_valid` drive the operation decoder directly; the decoder is purely combinational, so `op` must stay stable while `op_valid` is high.

## Interface
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit cell; must be ≥ 4.
- `clk`  in  1  system clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `serial_in`  in  1  raw serial line from the host, idle high, asynchronous to `clk`.
- `op`  out  24  last received operation word, MSB = first data bit received.
- `op_valid`  out  1  one-cycle strobe; `op` holds a new word.
- `frame_error`  out  1  one-cycle strobe; stop bit sampled low.
- `busy`  out  1  high while a frame is in progress (START, DATA or STOP state) and in BREAK.

## Operation
- Input conditioning:
  - `serial_in` passes through a 2-FF synchronizer; all logic uses the synchronized value `rx`.
  - `rx` resets to 1.
- Frame format: start bit (0), 24 data bits MSB-first, stop bit (1).
- Bit-cell counter `cnt` has width clog2(CLKS_PER_BIT). Bit counter `bitn` is 5 bits.
- FSM states and transitions:
  - IDLE:
    - A falling edge of `rx` (previous 1, current 0) loads `cnt` = CLKS_PER_BIT/2 − 1 and moves to START.
  - START:
    - `cnt` counts down to 0, then `rx` is sampled.
    - Sample 0: go to DATA, `cnt` = CLKS_PER_BIT − 1, `bitn` = 0.
    - Sample 1: glitch, return to IDLE with no strobe.
  - DATA:
    - At each `cnt` = 0, shift `rx` into the 24-bit shift register `sr` (`sr` <= {`sr`[22:0], rx}), reload `cnt`, and increment `bitn`.
    - After the shift with `bitn` = 23, go to STOP.
  - STOP:
    - At `cnt` = 0, sample `rx`.
    - Sample 1: `op` <= `sr`, pulse `op_valid`, go to IDLE.
    - Sample 0: pulse `frame_error`, leave `op` unchanged, go to BREAK.
  - BREAK:
    - Wait until `rx` = 1, then go to IDLE.
    - This prevents a held-low line from being read as back-to-back frames.
- `op` is a holding register. It changes only on the cycle `op_valid` is asserted.
- `op_valid` and `frame_error` are never high in the same cycle.
- No back-pressure: the downstream decoder consumes the word in the strobe cycle.

## Timing
- Reset values:
  - `op` = 24'h000000
  - `op_valid` = 0, `frame_error` = 0, `busy` = 0
  - FSM = IDLE, `sr` = 0, `cnt` = 0, `bitn` = 0
  - both synchronizer flops = 1
- Input latency: 2 `clk` from a `serial_in` edge to `rx`.
- Sampling point: mid-cell. Start bit is sampled CLKS_PER_BIT/2 cycles after the detected edge; each later bit is sampled CLKS_PER_BIT cycles after the previous sample.
- Frame latency: `op_valid` is registered and rises 1 cycle after the stop-bit sample, about 2 + 25.5·CLKS_PER_BIT cycles after the start edge on `serial_in`. It lasts exactly 1 cycle.
- Back-to-back frames: a start edge arriving in the same cycle `op_valid` is high must be accepted. IDLE is re-entered on the cycle of the stop sample, so the minimum inter-frame gap is half a bit cell of stop.
- Reset mid-frame: asserting `nrst` in any state immediately forces all reset values. A partial word is discarded; no strobe is issued on release.
- The falling-edge detector uses a registered previous `rx`, which resets to 1. A line already low at reset release therefore does not start a frame until it returns high and falls again.

## Configuration
- `OPRX_MAJORITY_EN` defined:
  - Every bit sample (start, data, stop) is the 2-of-3 majority of `rx` at the cycles `cnt` = 1, 0 and the cycle before `cnt` = 1.
  - Requires CLKS_PER_BIT ≥ 4.
  - Adds no latency, because the vote is formed by the `cnt` = 0 cycle.
- Not defined: a single sample of `rx` at `cnt` = 0.
- In both builds, IDLE edge detection uses the raw synchronized `rx`.

## Test plan
- Valid frame: CLKS_PER_BIT = 8, send 0xC71234 -> exactly one `op_valid` pulse, `op` = 24'hC71234, `frame_error` never high, `busy` low after the stop sample.
- Back-to-back frames: 0xC5EF00 then 0xFFFFFF with a half-cell stop gap -> two `op_valid` pulses; `op` equals each word in turn; `op` is stable for the whole interval between strobes.
- Framing error: 0x0B0000 sent with a stop bit of 0 held low for 3 cells -> one `frame_error` pulse, no `op_valid`, `op` keeps its previous value, `busy` stays high until the line rises. No further frame starts until the line falls again.
- Glitch: a 2-cycle low pulse on an idle line -> FSM returns to IDLE after the start sample, no strobes.
- Reset mid-frame: assert `nrst` after 10 data bits of 0xC40300 -> all outputs return to reset values; the next full frame 0xC40300 is received correctly.
- Noise (`OPRX_MAJORITY_EN` defined): invert `rx` for one cycle at `cnt` = 0 on every data bit of 0x030000 -> `op` = 24'h030000. Without the macro, the same stimulus yields `op` = 24'hFCFFFF.
